// File: rtl/store_buffer_if.sv
// Signal bundle between the memory stage, the store buffer and the data memory write port.
// The slave modport is the buffer's view; master is the view of its surroundings.
interface store_buffer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_type;
    logic [31:0]   st_pc;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_stall;
    logic          dm_ready;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_pc;
    logic [2:0]    dm_type;
    logic          err;
    logic [31:0]   err_pc;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_type, st_pc,
        input  ld_valid, ld_addr, dm_ready,
        output st_ready, ld_stall,
        output dm_we, dm_addr, dm_wdata, dm_pc, dm_type,
        output err, err_pc, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_type, st_pc,
        output ld_valid, ld_addr, dm_ready,
        input  st_ready, ld_stall,
        input  dm_we, dm_addr, dm_wdata, dm_pc, dm_type,
        input  err, err_pc, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between the memory stage and the data memory write port.
// It rejects misaligned or illegal stores and holds off loads that hit a pending store word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0]    TYPE_WORD  = 3'b000;
    localparam logic [2:0]    TYPE_HALF  = 3'b001;
    localparam logic [2:0]    TYPE_BYTE  = 3'b010;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Alignment rules: words on 4-byte, halves on 2-byte, bytes anywhere.
    function automatic logic is_legal(input logic [2:0] typ, input logic [1:0] low);
        logic ok;
        ok = 1'b0;
        case (typ)
            TYPE_WORD: ok = (low == 2'b00);
            TYPE_HALF: ok = (low[0] == 1'b0);
            TYPE_BYTE: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Hazards are tracked per word, so byte/half stores block the whole word.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return (a[AW+1:2] == b[AW+1:2]);
    endfunction

    logic [31:0]   addr_mem_r [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [2:0]    type_mem_r [DEPTH];

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          err_r;
    logic [31:0]   err_pc_r;

    logic [PW-1:0] rd_ptr_nx_s;
    logic [PW-1:0] wr_ptr_nx_s;
    logic [CW-1:0] count_nx_s;
    logic          st_ready_s;
    logic          legal_s;
    logic          push_s;
    logic          reject_s;
    logic          dm_we_s;
    logic          pop_s;
    logic [DEPTH-1:0] entry_valid_s;
    logic          entry_hit_s;
    logic          push_hit_s;
    logic          ld_stall_s;

    // Accept/drain handshake decode; a full buffer refuses even if it pops this cycle.
    always_comb begin
        st_ready_s = (count_r != FULL_COUNT);
        legal_s    = is_legal(bus.st_type, bus.st_addr[1:0]);
        push_s     = bus.st_valid & st_ready_s & legal_s;
        reject_s   = bus.st_valid & st_ready_s & ~legal_s;
        dm_we_s    = (count_r != CNT_ZERO);
        pop_s      = dm_we_s & bus.dm_ready;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_nx_s = rd_ptr_r;
        wr_ptr_nx_s = wr_ptr_r;
        count_nx_s  = count_r;
        if (push_s) begin
            wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid_s[i] = ({1'b0, PW'(i) - rd_ptr_r} < count_r);
        end
    end

    // Load hazard against buffered entries and against a store entering this cycle.
    always_comb begin
        entry_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i] && same_word(addr_mem_r[i], bus.ld_addr)) begin
                entry_hit_s = 1'b1;
            end else begin
                entry_hit_s = entry_hit_s;
            end
        end
        push_hit_s = push_s & same_word(bus.st_addr, bus.ld_addr);
        ld_stall_s = bus.ld_valid & (entry_hit_s | push_hit_s);
    end

    // Control state; reset discards every pending store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            err_r    <= 1'b0;
            err_pc_r <= 32'h0000_0000;
        end else begin
            rd_ptr_r <= rd_ptr_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            count_r  <= count_nx_s;
            err_r    <= reject_s;
            if (reject_s) begin
                err_pc_r <= bus.st_pc;
            end
        end
    end

    // Payload array; contents are only meaningful while the entry is live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= bus.st_addr;
            data_mem_r[wr_ptr_r] <= bus.st_data;
            pc_mem_r[wr_ptr_r]   <= bus.st_pc;
            type_mem_r[wr_ptr_r] <= bus.st_type;
        end
    end

    assign bus.st_ready = st_ready_s;
    assign bus.ld_stall = ld_stall_s;
    assign bus.dm_we    = dm_we_s;
    assign bus.dm_addr  = addr_mem_r[rd_ptr_r];
    assign bus.dm_wdata = data_mem_r[rd_ptr_r];
    assign bus.dm_pc    = pc_mem_r[rd_ptr_r];
    assign bus.dm_type  = type_mem_r[rd_ptr_r];
    assign bus.err      = err_r;
    assign bus.err_pc   = err_pc_r;
    assign bus.count    = count_r;
    assign bus.empty    = (count_r == CNT_ZERO);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain timing, fill/backpressure, wrap, hazards, rejects.
module tb_store_buffer;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [2:0]  typ;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   max_count = 0;
    wr_t  log_q[$];

    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(4)) sb();

    store_buffer #(.DEPTH(4), .AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb)
    );

    // Record every write the memory accepts, and the peak occupancy.
    always @(posedge clk) begin
        wr_t w;
        if (reset && sb.dm_we && sb.dm_ready) begin
            w.addr = sb.dm_addr;
            w.data = sb.dm_wdata;
            w.pc   = sb.dm_pc;
            w.typ  = sb.dm_type;
            log_q.push_back(w);
        end
        if (int'(sb.count) > max_count) max_count = int'(sb.count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t, input logic [31:0] pc);
        sb.st_valid = 1'b1;
        sb.st_addr  = a;
        sb.st_data  = d;
        sb.st_type  = t;
        sb.st_pc    = pc;
        tick();
        sb.st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sb.st_valid = 1'b0; sb.st_addr = 32'h0; sb.st_data = 32'h0; sb.st_type = 3'b000; sb.st_pc = 32'h0;
        sb.ld_valid = 1'b1; sb.ld_addr = 32'h0; sb.dm_ready = 1'b0;
        tick();
        tick();
        n_tests++; if (sb.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sb.count); end
        n_tests++; if (sb.st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready: got %b want 1", sb.st_ready); end
        n_tests++; if (sb.dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we: got %b want 0", sb.dm_we); end
        n_tests++; if (sb.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", sb.empty); end
        n_tests++; if (sb.ld_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ld_stall: got %b want 0", sb.ld_stall); end
        n_tests++; if (sb.err !== 1'b0 || sb.err_pc !== 32'h0) begin n_fail++; $display("FAIL reset_err: got %b/%h want 0/0", sb.err, sb.err_pc); end
        sb.ld_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_midrun();
        log_q.delete();
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h80 + 32'(4 * i), 32'h5555_0000 + 32'(i), 3'b000, 32'h1000 + 32'(4 * i));
        n_tests++; if (sb.count !== 3'd3) begin n_fail++; $display("FAIL midrun_count_before: got %0d want 3", sb.count); end
        reset = 1'b0;
        #1;
        n_tests++; if (sb.count !== 3'd0) begin n_fail++; $display("FAIL midrun_count: got %0d want 0", sb.count); end
        n_tests++; if (sb.dm_we !== 1'b0) begin n_fail++; $display("FAIL midrun_dm_we: got %b want 0", sb.dm_we); end
        n_tests++; if (sb.st_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_st_ready: got %b want 1", sb.st_ready); end
        tick();
        sb.dm_ready = 1'b1;
        reset = 1'b1;
        tick(); tick(); tick();
        n_tests++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL midrun_no_write: got %0d writes want 0", log_q.size()); end
    endtask

    task automatic test_single();
        log_q.delete();
        sb.dm_ready = 1'b1;
        push(32'h10, 32'hDEAD_BEEF, 3'b000, 32'h2000);
        n_tests++; if (sb.dm_we !== 1'b1) begin n_fail++; $display("FAIL single_dm_we: got %b want 1", sb.dm_we); end
        n_tests++; if (sb.dm_addr !== 32'h10) begin n_fail++; $display("FAIL single_dm_addr: got %h want 00000010", sb.dm_addr); end
        n_tests++; if (sb.dm_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_dm_wdata: got %h want deadbeef", sb.dm_wdata); end
        n_tests++; if (sb.dm_pc !== 32'h2000) begin n_fail++; $display("FAIL single_dm_pc: got %h want 00002000", sb.dm_pc); end
        tick();
        n_tests++; if (sb.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", sb.empty); end
        n_tests++; if (log_q.size() !== 1) begin n_fail++; $display("FAIL single_writes: got %0d want 1", log_q.size()); end
    endtask

    task automatic test_fill();
        logic acc;
        wr_t  exp;
        log_q.delete();
        max_count = 0;
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 3'b000, 32'h2100 + 32'(4 * i));
        n_tests++; if (sb.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", sb.count); end
        n_tests++; if (sb.st_ready !== 1'b0) begin n_fail++; $display("FAIL fill_st_ready: got %b want 0", sb.st_ready); end
        sb.st_valid = 1'b1; sb.st_addr = 32'h200; sb.st_data = 32'hA0A0_0004; sb.st_type = 3'b000; sb.st_pc = 32'h2110;
        tick();
        n_tests++; if (sb.count !== 3'd4) begin n_fail++; $display("FAIL fill_held: got %0d want 4", sb.count); end
        sb.dm_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc = sb.st_ready;
            tick();
            if (acc && sb.st_valid) sb.st_valid = 1'b0;
            if (!sb.st_valid && sb.empty) break;
        end
        sb.st_valid = 1'b0;
        n_tests++; if (sb.empty !== 1'b1) begin n_fail++; $display("FAIL fill_drain: got empty=%b want 1", sb.empty); end
        n_tests++; if (log_q.size() !== 5) begin n_fail++; $display("FAIL fill_writes: got %0d want 5", log_q.size()); end
        for (int i = 0; i < 5; i++) begin
            exp.addr = (i < 4) ? 32'h100 + 32'(4 * i) : 32'h200;
            exp.data = 32'hA0A0_0000 + 32'(i);
            exp.pc   = 32'h2100 + 32'(4 * i);
            exp.typ  = 3'b000;
            n_tests++;
            if (i >= log_q.size() || log_q[i] !== exp) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got %h want %h", i, (i < log_q.size()) ? log_q[i] : '0, exp);
            end
        end
        n_tests++; if (max_count > 4) begin n_fail++; $display("FAIL fill_max_count: got %0d want <=4", max_count); end
    endtask

    task automatic test_wrap();
        logic acc;
        wr_t  exp;
        log_q.delete();
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = (i % 2 == 0) ? 32'h40 + 32'(8 * i) : 32'h42 + 32'(8 * i);
            sb.st_type  = (i % 2 == 0) ? 3'b000 : 3'b001;
            sb.st_data  = 32'h1111_1111 * 32'(i);
            sb.st_pc    = 32'h4000 + 32'(4 * i);
            for (int k = 0; k < 10; k++) begin
                acc = sb.st_ready;
                sb.dm_ready = ~sb.dm_ready;
                tick();
                if (acc) break;
            end
        end
        sb.st_valid = 1'b0;
        sb.dm_ready = 1'b1;
        for (int k = 0; k < 20 && !sb.empty; k++) tick();
        n_tests++; if (log_q.size() !== 10) begin n_fail++; $display("FAIL wrap_writes: got %0d want 10", log_q.size()); end
        for (int i = 0; i < 10; i++) begin
            exp.addr = (i % 2 == 0) ? 32'h40 + 32'(8 * i) : 32'h42 + 32'(8 * i);
            exp.typ  = (i % 2 == 0) ? 3'b000 : 3'b001;
            exp.data = 32'h1111_1111 * 32'(i);
            exp.pc   = 32'h4000 + 32'(4 * i);
            n_tests++;
            if (i >= log_q.size() || log_q[i] !== exp) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, (i < log_q.size()) ? log_q[i] : '0, exp);
            end
        end
    endtask

    task automatic test_hazard();
        sb.dm_ready = 1'b0;
        push(32'h23, 32'h0000_00AB, 3'b010, 32'h5000);
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h20;
        #1;
        n_tests++; if (sb.ld_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_same_word: got %b want 1", sb.ld_stall); end
        sb.ld_addr = 32'h24;
        #1;
        n_tests++; if (sb.ld_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_next_word: got %b want 0", sb.ld_stall); end
        sb.ld_addr = 32'h1020;
        #1;
        n_tests++; if (sb.ld_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_alias_above_aw: got %b want 1", sb.ld_stall); end
        sb.st_valid = 1'b1; sb.st_addr = 32'h30; sb.st_type = 3'b000; sb.st_data = 32'h0; sb.st_pc = 32'h5004;
        sb.ld_addr = 32'h30;
        #1;
        n_tests++; if (sb.ld_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_push_cycle: got %b want 1", sb.ld_stall); end
        sb.st_type = 3'b011;
        #1;
        n_tests++; if (sb.ld_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_illegal_push: got %b want 0", sb.ld_stall); end
        sb.st_valid = 1'b0;
        sb.ld_addr = 32'h20;
        sb.dm_ready = 1'b1;
        tick();
        n_tests++; if (sb.ld_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_after_pop: got %b want 0", sb.ld_stall); end
        sb.ld_valid = 1'b0;
    endtask

    task automatic test_rejects();
        log_q.delete();
        sb.dm_ready = 1'b1;
        sb.st_valid = 1'b1; sb.st_addr = 32'h02; sb.st_type = 3'b000; sb.st_data = 32'h1; sb.st_pc = 32'h3004;
        tick();
        n_tests++; if (sb.err !== 1'b1 || sb.err_pc !== 32'h3004) begin n_fail++; $display("FAIL reject_word: got %b/%h want 1/00003004", sb.err, sb.err_pc); end
        sb.st_addr = 32'h11; sb.st_type = 3'b001; sb.st_pc = 32'h3008;
        tick();
        n_tests++; if (sb.err !== 1'b1 || sb.err_pc !== 32'h3008) begin n_fail++; $display("FAIL reject_half: got %b/%h want 1/00003008", sb.err, sb.err_pc); end
        sb.st_addr = 32'h00; sb.st_type = 3'b011; sb.st_pc = 32'h300C;
        tick();
        n_tests++; if (sb.err !== 1'b1 || sb.err_pc !== 32'h300C) begin n_fail++; $display("FAIL reject_type: got %b/%h want 1/0000300c", sb.err, sb.err_pc); end
        sb.st_valid = 1'b0;
        tick();
        n_tests++; if (sb.err !== 1'b0 || sb.err_pc !== 32'h300C) begin n_fail++; $display("FAIL reject_pulse_end: got %b/%h want 0/0000300c", sb.err, sb.err_pc); end
        n_tests++; if (sb.count !== 3'd0 || log_q.size() !== 0) begin n_fail++; $display("FAIL reject_not_queued: got count %0d writes %0d want 0/0", sb.count, log_q.size()); end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_single();
        test_fill();
        test_wrap();
        test_hazard();
        test_rejects();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry FIFO store buffer between the CPU memory stage and the data memory write port. Queues word/half/byte stores with their PC, drains one per cycle when the memory accepts, and rejects misaligned or illegal-type stores with an error pulse. Holds off loads whose word address matches a pending store so that loads never read stale data.

## Interface
- DEPTH, 4: entries; power of two, at least 2
- AW, 10: word-index bits compared for hazards (addr[AW+1:2])
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- st_valid  in  1  store request from memory stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  byte address
- st_data  in  32  store data; half uses [15:0], byte uses [7:0]
- st_type  in  3  000 word, 001 half, 010 byte
- st_pc  in  32  PC of the store instruction
- ld_valid  in  1  load in memory stage this cycle
- ld_addr  in  32  load byte address
- ld_stall  out  1  load must hold; buffered store hits same word
- dm_ready  in  1  data memory accepts a write this cycle
- dm_we  out  1  write strobe to data memory
- dm_addr, dm_wdata, dm_pc  out  32 each  head-entry fields
- dm_type  out  3  head-entry type
- err  out  1  one-cycle pulse: a store was rejected
- err_pc  out  32  PC of the most recent rejected store
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Storage: circular array with rd_ptr/wr_ptr of log2(DEPTH) bits (natural wrap) plus count register.
- Accept: push = st_valid & st_ready & legal; st_ready = (count != DEPTH).
- Legal: type 000 with addr[1:0]==00; type 001 with addr[0]==0; type 010 any address. Other types are illegal.
- Illegal store with st_valid & st_ready: not enqueued, err=1 next cycle, err_pc<=st_pc. Illegal store while full: no action until st_ready.
- Drain: dm_we = !empty; dm_* = head fields, combinational from registered state. pop = dm_we & dm_ready; rd_ptr advances on pop.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, st_ready=0 even if a pop occurs that cycle (no bypass).
- Hazard: ld_stall = ld_valid & (any valid entry, or a legal push this cycle, has addr[AW+1:2] == ld_addr[AW+1:2]). Comparison covers the whole word, regardless of type.
- Data passes unmodified; byte/half lane placement is done by data memory.

## Timing
- Reset (reset=0, asynchronous): count=0, pointers=0, err=0, err_pc=0. Outputs settle immediately: st_ready=1, dm_we=0, empty=1, ld_stall=0 (empty buffer). Entry payloads need not be cleared.
- Reset mid-operation discards all pending stores; none reaches memory after reset asserts.
- Store latency: a push at edge n gives dm_we=1 with that entry during cycle n+1, if it is at head. Written to memory at edge n+1 if dm_ready=1.
- Throughput: one push and one pop per cycle maximum. Entries drain in strict FIFO order.
- ld_stall deasserts combinationally in the cycle after the last matching entry pops.
- err is high for exactly one cycle per rejected store. Back-to-back rejects give consecutive pulses, with err_pc updated each time.

## Test plan
- Reset then idle: reset=0 mid-run with 3 entries queued -> count=0, dm_we=0, st_ready=1 immediately; no write after release.
- Single word store, dm_ready=1: push addr 0x10, data 0xDEADBEEF, type 000 at edge n -> dm_we=1, dm_addr=0x10 in cycle n+1; empty=1 in cycle n+2.
- Fill with dm_ready=0: push 4 stores -> count=4, st_ready=0. 5th st_valid held. Raise dm_ready -> entries exit in order, 5th accepted after first pop; count never exceeds 4.
- Wrap-around: 10 consecutive stores with dm_ready toggling 1/0 -> dm output sequence equals input sequence exactly.
- Hazard: queue byte store at 0x23, load at 0x20 with dm_ready=0 -> ld_stall=1. Load at 0x24 -> ld_stall=0. Release dm_ready -> ld_stall drops the cycle after pop.
- Rejects: word store at 0x02 PC 0x3004, half at 0x11, type 011 -> none enqueued; err pulses each next cycle; err_pc=0x3004 after the first reject.
